// File: rtl/ov7670_pkg.sv
// Shared constants for the OV7670 capture/readback path: arbiter state
// encodings, default buffer address width and burst counter width.
package ov7670_pkg;

  localparam int ADDR_W_DEF  = 19;
  localparam int BURST_CNT_W = 8;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_OWN  = 1'b1;

endpackage

// File: rtl/arb_rsp_pipe.sv
// Response tracker for the frame buffer read port: shifts {valid, owner}
// through DEPTH stages so the tag lines up with the RAM read data.
module arb_rsp_pipe #(
  parameter int DEPTH = 1,
  parameter int OWN_W = 1
) (
  input  logic             PCLK,
  input  logic             Reset,
  input  logic             in_vld,
  input  logic [OWN_W-1:0] in_own,
  output logic             out_vld,
  output logic [OWN_W-1:0] out_own
);

  logic [DEPTH-1:0] vld_q;
  logic [OWN_W-1:0] own_q [DEPTH];

  always_ff @(posedge PCLK) begin
    if (Reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) own_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      own_q[0] <= in_own;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_own = own_q[DEPTH-1];

endmodule

// File: rtl/frame_buffer_read_arbiter.sv
// Shares the frame buffer read port among NUM_REQ consumers with bounded bursts.
// Define ARB_FIXED_PRIO_EN for fixed priority with requester 0 exempt from burst rotation.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ARB_IDLE | no owner; pick next requester, grant appears next cycle
// ARB_OWN  | owner drives ReadAddr; release on swap/last/burst/timeout
module frame_buffer_read_arbiter
  import ov7670_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                      PCLK,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ-1:0]        ReqLast,
  input  logic                      FrameSwap,
  output logic [NUM_REQ-1:0]        Gnt,
  output logic [NUM_REQ-1:0]        Accept,
  output logic [ADDR_W-1:0]         ReadAddr,
  input  logic                      BufferData,
  output logic [NUM_REQ-1:0]        RspValid,
  output logic                      RspData
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [0:0]             state;
  logic [OWN_W-1:0]       owner;
  logic [OWN_W-1:0]       pick;
  logic                   pick_vld;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [BURST_CNT_W-1:0] burst_nxt;
  logic                   idle_miss;
  logic                   own_req;
  logic                   own_acc;
  logic                   burst_hit;
  logic                   release_own;
  logic                   pipe_vld;
  logic [OWN_W-1:0]       pipe_own;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (Req[i]) begin
        pick     = OWN_W'(i);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [OWN_W-1:0] rr_ptr;

  // Scan offsets high to low so the requester closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (Req[idx]) begin
        pick     = OWN_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (Reset) begin
      rr_ptr <= '0;
    end else if (release_own) begin
      rr_ptr <= (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end
`endif

  assign own_req   = Req[owner];
  assign own_acc   = (state == ARB_OWN) && own_req;
  assign burst_nxt = burst_cnt + 1'b1;

`ifdef ARB_FIXED_PRIO_EN
  assign burst_hit = own_acc && (burst_nxt == BURST_MAX) && (owner != '0);
`else
  assign burst_hit = own_acc && (burst_nxt == BURST_MAX);
`endif

  assign release_own = (state == ARB_OWN) &&
                       (FrameSwap || (own_acc && ReqLast[owner]) || burst_hit ||
                        (!own_req && idle_miss));

  assign Accept   = Gnt & Req;
  assign ReadAddr = (state == ARB_OWN) ? ReqAddr[int'(owner)*ADDR_W +: ADDR_W] : '0;

  always_ff @(posedge PCLK) begin
    if (Reset) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      Gnt       <= '0;
      burst_cnt <= '0;
      idle_miss <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            state     <= ARB_OWN;
            owner     <= pick;
            Gnt       <= ONE << pick;
            burst_cnt <= '0;
            idle_miss <= 1'b0;
          end
        end
        default: begin
          if (release_own) begin
            state     <= ARB_IDLE;
            Gnt       <= '0;
            burst_cnt <= '0;
            idle_miss <= 1'b0;
          end else begin
            if (own_acc) burst_cnt <= burst_nxt;
            idle_miss <= !own_req;
          end
        end
      endcase
    end
  end

  arb_rsp_pipe #(
    .DEPTH (RD_LAT),
    .OWN_W (OWN_W)
  ) u_rsp_pipe (
    .PCLK    (PCLK),
    .Reset   (Reset),
    .in_vld  (own_acc),
    .in_own  (owner),
    .out_vld (pipe_vld),
    .out_own (pipe_own)
  );

  always_comb begin
    RspValid = '0;
    if (pipe_vld) RspValid[pipe_own] = 1'b1;
  end

  assign RspData = pipe_vld & BufferData;

endmodule

// File: tb/tb_frame_buffer_read_arbiter.sv
// Directed bench for frame_buffer_read_arbiter: one RD_LAT=1 and one RD_LAT=3
// instance share stimulus; each has its own buffer RAM model.
module tb_frame_buffer_read_arbiter;

  logic        PCLK = 1'b0;
  logic        Reset;
  logic [1:0]  Req;
  logic [37:0] ReqAddr;
  logic [1:0]  ReqLast;
  logic        FrameSwap;

  logic [1:0]  Gnt_a, Accept_a, RspValid_a;
  logic [18:0] ReadAddr_a;
  logic        BufferData_a, RspData_a;
  logic [1:0]  Gnt_b, Accept_b, RspValid_b;
  logic [18:0] ReadAddr_b;
  logic        BufferData_b, RspData_b;

  logic [18:0] ra_a;
  logic [18:0] ra_b [3];

  int npass = 0;
  int ntot  = 0;
  int own;
  logic [18:0] a, pa;

  always #5 PCLK = ~PCLK;

  frame_buffer_read_arbiter #(.NUM_REQ(2), .ADDR_W(19), .MAX_BURST(16), .RD_LAT(1)) dut_a (
    .PCLK(PCLK), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqLast(ReqLast),
    .FrameSwap(FrameSwap), .Gnt(Gnt_a), .Accept(Accept_a), .ReadAddr(ReadAddr_a),
    .BufferData(BufferData_a), .RspValid(RspValid_a), .RspData(RspData_a));

  frame_buffer_read_arbiter #(.NUM_REQ(2), .ADDR_W(19), .MAX_BURST(16), .RD_LAT(3)) dut_b (
    .PCLK(PCLK), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqLast(ReqLast),
    .FrameSwap(FrameSwap), .Gnt(Gnt_b), .Accept(Accept_b), .ReadAddr(ReadAddr_b),
    .BufferData(BufferData_b), .RspValid(RspValid_b), .RspData(RspData_b));

  function automatic logic pix(input logic [18:0] ad);
    return ad[0] ^ ad[1] ^ ad[3];
  endfunction

  always @(posedge PCLK) begin
    ra_a    <= ReadAddr_a;
    ra_b[0] <= ReadAddr_b;
    ra_b[1] <= ra_b[0];
    ra_b[2] <= ra_b[1];
  end
  assign BufferData_a = pix(ra_a);
  assign BufferData_b = pix(ra_b[2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_addr(input int r, input logic [18:0] ad);
    ReqAddr[r*19 +: 19] = ad;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Req = '0; ReqLast = '0; FrameSwap = 1'b0; ReqAddr = '0;
    repeat (2) @(negedge PCLK);
    Reset = 1'b0;
  endtask

  initial begin
    // Reset values, then requester 0 streaming addresses 0..19 with no ReqLast
    do_reset();
    #1;
    chk("rst_gnt", Gnt_a, 0);
    chk("rst_rspv", RspValid_a, 0);
    chk("rst_rspd", RspData_a, 0);
    chk("rst_raddr", ReadAddr_a, 0);
    chk("rst_acc", Accept_a, 0);
    Req = 2'b01; set_addr(0, 19'd0); set_addr(1, 19'h7ffff);
    #1; chk("b_idle_gnt", Gnt_a, 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK); set_addr(0, 19'(k - 1)); #1;
      chk("b_gnt", Gnt_a, 1);
      chk("b_raddr", ReadAddr_a, k - 1);
      chk("b_rspv", RspValid_a, (k >= 2) ? 1 : 0);
      if (k >= 2) chk("b_rspd", RspData_a, pix(19'(k - 2)));
      chk("b_rspv3", RspValid_b, (k >= 4) ? 1 : 0);
      if (k >= 4) chk("b_rspd3", RspData_b, pix(19'(k - 4)));
    end
    @(negedge PCLK); set_addr(0, 19'd16); #1;
    chk("b_gap_gnt", Gnt_a, 0);
    chk("b_gap_acc", Accept_a, 0);
    chk("b_gap_rspv", RspValid_a, 1);
    chk("b_gap_rspd", RspData_a, pix(19'd15));
    @(negedge PCLK); #1;
    chk("b_regrant", Gnt_a, 1);
    chk("b_regrant_addr", ReadAddr_a, 16);
    chk("b_regrant_rspv", RspValid_a, 0);
    for (int k = 17; k <= 19; k++) begin
      @(negedge PCLK); set_addr(0, 19'(k)); #1;
      chk("b_tail_gnt", Gnt_a, 1);
      chk("b_tail_rspd", RspData_a, pix(19'(k - 1)));
    end

    // Both requesting, ReqLast on every 3rd accept: grants alternate 0,1,0,1
    do_reset();
    Req = 2'b11; #1;
    chk("rr_gap0", Gnt_a, 0);
    for (int g = 0; g < 4; g++) begin
      own = g % 2;
      for (int j = 0; j < 3; j++) begin
        @(negedge PCLK);
        a = 19'(g * 8 + j + 1);
        set_addr(own, a); set_addr(1 - own, a ^ 19'h40000);
        ReqLast = (j == 2) ? 2'(1 << own) : 2'b00;
        #1;
        chk("rr_gnt", Gnt_a, 1 << own);
        chk("rr_acc", Accept_a, 1 << own);
        chk("rr_raddr", ReadAddr_a, a);
        if (j == 0) chk("rr_rspv_first", RspValid_a, 0);
        else begin
          chk("rr_rspv", RspValid_a, 1 << own);
          chk("rr_rspd", RspData_a, pix(pa));
        end
        pa = a;
      end
      @(negedge PCLK); ReqLast = 2'b00; #1;
      chk("rr_gap", Gnt_a, 0);
      chk("rr_rspv_gap", RspValid_a, 1 << own);
      chk("rr_rspd_gap", RspData_a, pix(pa));
    end

    // FrameSwap in IDLE is ignored; FrameSwap on 5th accept of requester 1 releases
    do_reset();
    Req = 2'b10; FrameSwap = 1'b1; #1;
    chk("fs_idle_gnt", Gnt_a, 0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge PCLK);
      FrameSwap = (j == 5); Req = 2'b11;
      a = 19'(200 + j); set_addr(1, a); set_addr(0, 19'h123);
      #1;
      chk("fs_gnt", Gnt_a, 2);
      chk("fs_raddr", ReadAddr_a, a);
      if (j > 1) begin
        chk("fs_rspv", RspValid_a, 2);
        chk("fs_rspd", RspData_a, pix(pa));
      end
      pa = a;
    end
    @(negedge PCLK); FrameSwap = 1'b0; #1;
    chk("fs_gap", Gnt_a, 0);
    chk("fs_rspv5", RspValid_a, 2);
    chk("fs_rspd5", RspData_a, pix(pa));
    @(negedge PCLK); #1;
    chk("fs_regrant0", Gnt_a, 1);
    chk("fs_raddr0", ReadAddr_a, 19'h123);

    // One-cycle bubble keeps the grant; two idle cycles release and advance rr
    do_reset();
    Req = 2'b01; set_addr(0, 19'd5); #1;
    @(negedge PCLK); #1;
    chk("to_acc1", Accept_a, 1);
    @(negedge PCLK); Req = 2'b00; #1;
    chk("to_bub_gnt", Gnt_a, 1);
    chk("to_bub_acc", Accept_a, 0);
    chk("to_bub_rspv", RspValid_a, 1);
    @(negedge PCLK); Req = 2'b01; #1;
    chk("to_keep", Gnt_a, 1);
    chk("to_acc2", Accept_a, 1);
    chk("to_bub_norsp", RspValid_a, 0);
    @(negedge PCLK); Req = 2'b00; #1;
    chk("to_miss1", Gnt_a, 1);
    @(negedge PCLK); #1;
    chk("to_miss2", Gnt_a, 1);
    @(negedge PCLK); Req = 2'b11; #1;
    chk("to_gap", Gnt_a, 0);
    @(negedge PCLK); #1;
    chk("to_rr1", Gnt_a, 2);

    // RD_LAT=3 instance: reset one cycle after an accept kills the in-flight read
    do_reset();
    Req = 2'b01; set_addr(0, 19'd9); #1;
    @(negedge PCLK); #1;
    chk("rl3_acc", Accept_b, 1);
    @(negedge PCLK); Reset = 1'b1; Req = 2'b00; #1;
    @(negedge PCLK); Reset = 1'b0; #1;
    chk("rl3_gnt", Gnt_b, 0);
    chk("rl3_rspv", RspValid_b, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK); #1;
      chk("rl3_norsp", RspValid_b, 0);
      chk("rl3_nognt", Gnt_b, 0);
    end

    // Both requesting, no ReqLast
    do_reset();
    Req = 2'b11; set_addr(0, 19'd77); set_addr(1, 19'd88); #1;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK); #1;
      chk("fp_gnt0", Gnt_a, 1);
    end
    @(negedge PCLK); Req = 2'b10; #1;
    chk("fp_miss1", Gnt_a, 1);
    @(negedge PCLK); #1;
    chk("fp_miss2", Gnt_a, 1);
    @(negedge PCLK); #1;
    chk("fp_gap", Gnt_a, 0);
    @(negedge PCLK); #1;
    chk("fp_gnt1", Gnt_a, 2);
    chk("fp_raddr1", ReadAddr_a, 88);
`else
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK); #1;
      chk("mb_gnt0", Gnt_a, 1);
    end
    @(negedge PCLK); #1;
    chk("mb_gap", Gnt_a, 0);
    @(negedge PCLK); #1;
    chk("mb_gnt1", Gnt_a, 2);
    chk("mb_raddr1", ReadAddr_a, 88);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/frame_buffer_read_arbiter.md
Name: frame_buffer_read_arbiter

Overview:
- Shares the single read port of the binarized double frame buffer (ReadAddr/BufferData) among NUM_REQ consumers, e.g. blob detector, display scanout and debug readback.
- Round-robin arbitration with bounded bursts.
- Tags each read with its owner and routes the returned pixel bit back after the fixed RAM read latency.
- Drops ownership on a buffer swap so no burst straddles two frames.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 19, buffer address width.
- MAX_BURST, 16, maximum consecutive accepted reads per grant before forced rotation (1..255).
- RD_LAT, 1, buffer read latency in PCLK cycles (1..4).

Ports:
- PCLK  in  1  pixel clock.
- Reset  in  1  synchronous reset, active-high.
- Req  in  NUM_REQ  per-requester read request, held until accepted.
- ReqAddr  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- ReqLast  in  NUM_REQ  marks the final read of a requester's burst.
- FrameSwap  in  1  one-cycle pulse when the capture side toggles its active buffer.
- Gnt  out  NUM_REQ  one-hot ownership, registered.
- Accept  out  NUM_REQ  read accepted this cycle: Gnt[i] & Req[i].
- ReadAddr  out  ADDR_W  address to buffer read port.
- BufferData  in  1  buffer read data.
- RspValid  out  NUM_REQ  returned data valid for requester i.
- RspData  out  1  returned pixel bit, shared by all requesters.

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock PCLK.
- Reset values:
  - state IDLE, Gnt=0, RspValid=0, RspData=0.
  - rr pointer=0, burst count=0, response pipeline cleared.
  - ReadAddr=0.
- States:
  - IDLE: no owner. If any Req, pick the first requester at or after the rr pointer (wrapping), then go to OWN. Gnt rises the next cycle.
  - OWN: Gnt[owner]=1. ReadAddr = ReqAddr[owner], combinational mux from the registered owner index.
- Handshake:
  - Accept[owner] = Req[owner] in OWN. Each accept increments the burst count (8 bits).
  - A requester may deassert Req mid-ownership without losing the grant (bubble). A bubble does not count toward the burst.
- Release from OWN happens on any of these; the first match wins, all are evaluated in the same cycle:
  - FrameSwap.
  - Accept with ReqLast.
  - Accept making the count equal MAX_BURST.
  - Req[owner]=0 for 2 consecutive cycles (idle timeout).
- On release:
  - rr pointer = owner+1 mod NUM_REQ; count=0.
  - Next state is IDLE. Re-arbitration costs one cycle, so Gnt is all-zero for exactly 1 cycle between owners.
- FrameSwap in IDLE: no effect. FrameSwap coinciding with an accept: that read completes (response delivered) and ownership still drops.
- Response path:
  - A shift pipeline of depth RD_LAT carries {valid, owner}.
  - RspValid[i] rises exactly RD_LAT cycles after Accept[i], with RspData = BufferData sampled that cycle.
  - In-flight responses are never cancelled by release, FrameSwap, or a new grant. Reset clears them.
- Reset asserted mid-burst: the next cycle shows Gnt=0 and RspValid=0; no stale response appears afterwards.
- Single requester at MAX_BURST: it regains the grant after the 1-cycle gap if it is still requesting.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- When defined:
  - IDLE always selects the lowest-index requesting requester; the rr pointer is unused.
  - MAX_BURST rotation applies only to requesters other than index 0, so requester 0 (display scanout) is never preempted except by ReqLast, FrameSwap or idle timeout.
- When undefined: round-robin as above.

Decomposition:
- Shared package ov7670_pkg holds:
  - state encodings ARB_IDLE/ARB_OWN.
  - ADDR_W default 19.
  - the max_burst counter width constant.
- One natural sub-module, arb_rsp_pipe: RD_LAT-deep valid/owner shift register with synchronous clear.

Test Plan:
- NUM_REQ=2, RD_LAT=1, Req0 constant with addresses 0..19 and no ReqLast:
  - 16 accepts (addr 0..15), then Gnt=0 for 1 cycle, then Gnt0 again.
  - RspValid0 follows each accept by 1 cycle with the matching bits.
- Req0 and Req1 both high, ReqLast on the 3rd accept of each:
  - grants alternate 0,1,0,1.
  - each grant delivers exactly 3 responses to the correct RspValid bit.
- FrameSwap pulsed on the 5th accept of requester 1:
  - 5 responses are delivered.
  - Gnt1 drops the next cycle; requester 0 gets the grant after the gap.
- Requester 0 owns and drops Req for 1 cycle then resumes: grant is retained. It then drops Req for 2 cycles: release, rr pointer advances to 1.
- RD_LAT=3, Reset asserted 1 cycle after an accept: no RspValid in any later cycle; Gnt=0 the next cycle.
- ARB_FIXED_PRIO_EN, both requesting, no ReqLast:
  - requester 0 performs 40 accepts without rotation.
  - on its idle timeout, requester 1 is granted.
